// File: rtl/seqpu_cpu_if.sv
// seqpu_cpu memory bus.
// Shared program/data port of the seqpu core.
interface seqpu_cpu_if;
  logic [15:0] address;
  logic [15:0] data_out;
  logic [15:0] data_in;
  logic        wren_n;
  logic        oen_n;

  modport master (
    output address,
    output data_out,
    output wren_n,
    output oen_n,
    input  data_in
  );

  modport slave (
    input  address,
    input  data_out,
    input  wren_n,
    input  oen_n,
    output data_in
  );
endinterface

// File: rtl/seqpu_cpu.sv
// seqpu_cpu: multi-cycle 16-bit accumulator core.
// Fetch/decode/exec/mem over one synchronous memory port.
module seqpu_cpu (
  input  logic        clk,
  input  logic        rst_n,
  seqpu_cpu_if.master bus
);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    HALT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] a_q, a_d;
  logic        c_q, c_d;

  logic [3:0]  op;
  logic [15:0] kaddr;
  logic [16:0] sum;
  logic [16:0] diff;

  logic op_ldi, op_st, op_mem, op_jmp;
  logic op_jz, op_jc, op_hlt;

  assign op    = ir_q[15:12];
  assign kaddr = {4'h0, ir_q[11:0]};
  assign sum   = {1'b0, a_q} + {1'b0, bus.data_in};
  assign diff  = {1'b0, a_q} + {1'b0, ~bus.data_in} + 17'd1;

  assign op_ldi = (op == 4'h1);
  assign op_st  = (op == 4'h3);
  assign op_mem = (op == 4'h2) ||
                  (op >= 4'h4 && op <= 4'h8);
  assign op_jmp = (op == 4'h9);
  assign op_jz  = (op == 4'hA);
  assign op_jc  = (op == 4'hB);
  assign op_hlt = (op == 4'hC);

  assign bus.data_out = a_q;

  // State register and architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= 16'h0;
      ir_q    <= 16'h0;
      a_q     <= 16'h0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      c_q     <= c_d;
    end
  end

  // Next-state, register updates and bus strobes
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    c_d         = c_q;
    bus.address = pc_q;
    bus.oen_n   = 1'b1;
    bus.wren_n  = 1'b1;
    unique case (state_q)
      FETCH: begin
        bus.oen_n = 1'b0;
        state_d   = DECODE;
      end
      DECODE: begin
        ir_d    = bus.data_in;
        pc_d    = pc_q + 16'd1;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        unique case (1'b1)
          op_ldi: a_d = kaddr;
          op_st: begin
            bus.address = kaddr;
            bus.wren_n  = 1'b0;
          end
          op_mem: begin
            bus.address = kaddr;
            bus.oen_n   = 1'b0;
            state_d     = MEM;
          end
          op_jmp: pc_d = kaddr;
          op_jz: begin
            if (a_q == 16'h0) pc_d = kaddr;
          end
          op_jc: begin
            if (c_q) pc_d = kaddr;
          end
          op_hlt: state_d = HALT;
          default: ;
        endcase
      end
      MEM: begin
        state_d = FETCH;
        case (op)
          4'h2: a_d = bus.data_in;
          4'h4: {c_d, a_d} = sum;
          4'h5: {c_d, a_d} = diff;
          4'h6: a_d = a_q & bus.data_in;
          4'h7: a_d = a_q | bus.data_in;
          4'h8: a_d = a_q ^ bus.data_in;
          default: ;
        endcase
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_seqpu_cpu.sv
// Testbench for seqpu_cpu.
// Directed programs on a one-cycle-latency memory model.
module tb_seqpu_cpu;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic        clr;
  logic        pwe;
  logic [11:0] paddr;
  logic [15:0] pdata;
  logic [15:0] mem [0:4095];

  seqpu_cpu_if bus ();

  seqpu_cpu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block RAM model with a bench-side load/clear port
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 16'h0;
    end else if (pwe) begin
      mem[paddr] <= pdata;
    end else if (!bus.wren_n) begin
      mem[bus.address[11:0]] <= bus.data_out;
    end
    if (!bus.oen_n) bus.data_in <= mem[bus.address[11:0]];
  end

  task automatic start_prog();
    rst_n = 1'b0;
    clr   = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic put(input logic [11:0] a,
                     input logic [15:0] d);
    pwe   = 1'b1;
    paddr = a;
    pdata = d;
    @(posedge clk);
    #1;
    pwe = 1'b0;
  endtask

  // Release reset and run until halted.
  // cyc = cycles from release to first HALT cycle.
  task automatic run(output int cyc,
                     output int wrs,
                     output logic [15:0] haddr);
    int n;
    int rl;
    int st;
    bit done;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n = 0; rl = 0; st = 0; wrs = 0;
    done = 1'b0; cyc = -1; haddr = 16'hxxxx;
    while (!done && n < 3000) begin
      if (bus.wren_n === 1'b0) wrs++;
      if (bus.oen_n === 1'b1 && bus.wren_n === 1'b1) begin
        if (rl == 0) st = n;
        rl++;
      end else begin
        rl = 0;
      end
      if (rl == 4) begin
        done  = 1'b1;
        cyc   = st + 2;
        haddr = bus.address;
      end else begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: no halt after %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    start_prog();
    put(12'h000, 16'h1001);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.address !== 16'h0) begin
      errors++;
      $display("FAIL rst_address: got %h want 0000", bus.address);
    end
    checks++;
    if (bus.wren_n !== 1'b1) begin
      errors++;
      $display("FAIL rst_wren_n: got %b want 1", bus.wren_n);
    end
    checks++;
    if (bus.data_out !== 16'h0) begin
      errors++;
      $display("FAIL rst_data_out: got %h want 0000", bus.data_out);
    end
    checks++;
    if (bus.oen_n !== 1'b0) begin
      errors++;
      $display("FAIL rst_oen_n: got %b want 0", bus.oen_n);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.oen_n !== 1'b0 || bus.address !== 16'h0) begin
      errors++;
      $display("FAIL first_fetch: got oen_n=%b addr=%h want 0/0000",
               bus.oen_n, bus.address);
    end
  endtask

  task automatic test_ldi_st();
    int cyc;
    int wrs;
    logic [15:0] ha;
    start_prog();
    put(12'h000, 16'h1123);
    put(12'h001, 16'h3100);
    put(12'h002, 16'hC000);
    run(cyc, wrs, ha);
    checks++;
    if (mem[12'h100] !== 16'h0123) begin
      errors++;
      $display("FAIL ldi_st_mem: got %h want 0123", mem[12'h100]);
    end
    checks++;
    if (wrs !== 1) begin
      errors++;
      $display("FAIL ldi_st_wren_cycles: got %0d want 1", wrs);
    end
    checks++;
    if (ha !== 16'h0003) begin
      errors++;
      $display("FAIL ldi_st_halt_pc: got %h want 0003", ha);
    end
    checks++;
    if (cyc !== 9) begin
      errors++;
      $display("FAIL ldi_st_cycles: got %0d want 9", cyc);
    end
  endtask

  task automatic test_add_carry();
    int cyc;
    int wrs;
    logic [15:0] ha;
    start_prog();
    put(12'h080, 16'hFFFF);
    put(12'h000, 16'h1001);
    put(12'h001, 16'h4080);
    put(12'h002, 16'h3081);
    put(12'h003, 16'hB005);
    put(12'h004, 16'hC000);
    put(12'h005, 16'h10AA);
    put(12'h006, 16'h3082);
    put(12'h007, 16'hC000);
    run(cyc, wrs, ha);
    checks++;
    if (mem[12'h081] !== 16'h0000) begin
      errors++;
      $display("FAIL add_sum: got %h want 0000", mem[12'h081]);
    end
    checks++;
    if (mem[12'h082] !== 16'h00AA) begin
      errors++;
      $display("FAIL add_carry_jc: got %h want 00aa", mem[12'h082]);
    end
    checks++;
    if (ha !== 16'h0008 || cyc !== 22) begin
      errors++;
      $display("FAIL add_halt: got pc=%h cyc=%0d want 0008/22", ha, cyc);
    end
  endtask

  task automatic test_sub_borrow();
    int cyc;
    int wrs;
    logic [15:0] ha;
    start_prog();
    put(12'h080, 16'h0003);
    put(12'h000, 16'h1002);
    put(12'h001, 16'h5080);
    put(12'h002, 16'h3081);
    put(12'h003, 16'hB008);
    put(12'h004, 16'hA008);
    put(12'h005, 16'h1055);
    put(12'h006, 16'h3082);
    put(12'h007, 16'hC000);
    put(12'h008, 16'h10EE);
    put(12'h009, 16'h3082);
    put(12'h00A, 16'hC000);
    run(cyc, wrs, ha);
    checks++;
    if (mem[12'h081] !== 16'hFFFF) begin
      errors++;
      $display("FAIL sub_result: got %h want ffff", mem[12'h081]);
    end
    checks++;
    if (mem[12'h082] !== 16'h0055) begin
      errors++;
      $display("FAIL sub_no_jump: got %h want 0055", mem[12'h082]);
    end
    checks++;
    if (ha !== 16'h0008 || cyc !== 25) begin
      errors++;
      $display("FAIL sub_halt: got pc=%h cyc=%0d want 0008/25", ha, cyc);
    end
  endtask

  task automatic test_loop();
    int cyc;
    int wrs;
    logic [15:0] ha;
    start_prog();
    put(12'h080, 16'h0001);
    put(12'h000, 16'h1005);
    put(12'h001, 16'h3090);
    put(12'h002, 16'h2091);
    put(12'h003, 16'h4080);
    put(12'h004, 16'h3091);
    put(12'h005, 16'h2090);
    put(12'h006, 16'h5080);
    put(12'h007, 16'h3090);
    put(12'h008, 16'hA00A);
    put(12'h009, 16'h9002);
    put(12'h00A, 16'hC000);
    run(cyc, wrs, ha);
    checks++;
    if (mem[12'h091] !== 16'h0005) begin
      errors++;
      $display("FAIL loop_iters: got %h want 0005", mem[12'h091]);
    end
    checks++;
    if (mem[12'h090] !== 16'h0000) begin
      errors++;
      $display("FAIL loop_counter: got %h want 0000", mem[12'h090]);
    end
    checks++;
    if (cyc !== 146) begin
      errors++;
      $display("FAIL loop_cycles: got %0d want 146", cyc);
    end
    checks++;
    if (ha !== 16'h000B) begin
      errors++;
      $display("FAIL loop_halt_pc: got %h want 000b", ha);
    end
  endtask

  task automatic test_self_modify();
    int cyc;
    int wrs;
    logic [15:0] ha;
    start_prog();
    put(12'h080, 16'h10AB);
    put(12'h000, 16'h2080);
    put(12'h001, 16'h3002);
    put(12'h002, 16'hC000);
    put(12'h003, 16'h3081);
    put(12'h004, 16'hC000);
    run(cyc, wrs, ha);
    checks++;
    if (mem[12'h081] !== 16'h00AB || cyc !== 16) begin
      errors++;
      $display("FAIL self_modify: got m=%h cyc=%0d want 00ab/16",
               mem[12'h081], cyc);
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    int wrs;
    logic [15:0] ha;
    start_prog();
    put(12'h100, 16'hDEAD);
    put(12'h000, 16'h1077);
    put(12'h001, 16'h3100);
    put(12'h002, 16'hC000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (bus.wren_n !== 1'b0 || bus.address !== 16'h0100) begin
      errors++;
      $display("FAIL st_exec: got wren_n=%b addr=%h want 0/0100",
               bus.wren_n, bus.address);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.wren_n !== 1'b1 || bus.address !== 16'h0) begin
      errors++;
      $display("FAIL abort_outputs: got wren_n=%b addr=%h want 1/0000",
               bus.wren_n, bus.address);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mem[12'h100] !== 16'hDEAD) begin
      errors++;
      $display("FAIL abort_no_write: got %h want dead", mem[12'h100]);
    end
    run(cyc, wrs, ha);
    checks++;
    if (mem[12'h100] !== 16'h0077 || cyc !== 9) begin
      errors++;
      $display("FAIL restart: got m=%h cyc=%0d want 0077/9",
               mem[12'h100], cyc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clr    = 1'b0;
    pwe    = 1'b0;
    paddr  = 12'h0;
    pdata  = 16'h0;
    test_reset();
    test_ldi_st();
    test_add_carry();
    test_sub_borrow();
    test_loop();
    test_self_modify();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
